reg_file_wb: RTL
================

// Module: reg_file_wb
// PURPOSE
//   Register file plus writeback pipeline stage wrapped around the 8-bit ALU.
//   Supplies ALU operands inA/inB and the shift/carry input sc_i.
//   Captures the ALU result rslt and flags sc_o/one/pari one cycle later; commits rslt on the following edge.
//   Sits directly upstream (operands) and downstream (results) of the ALU in the X9 datapath.
// PARAMETERS
//   D   8   data width (matches ALU operand/result width)
//   A   3   register address width; 2**A architectural registers
// PORTS
//   clk        in   1   single system clock, all state updates on posedge
//   reset      in   1   synchronous, active-high reset
//   rd_addrA   in   A   read port A address
//   rd_addrB   in   A   read port B address
//   datA_out   out  D   operand A to ALU inA (combinational read)
//   datB_out   out  D   operand B to ALU inB (combinational read)
//   wr_en      in   1   request writeback of wr_data to wr_addr
//   wr_addr    in   A   destination register
//   wr_data    in   D   value to write (ALU rslt)
//   sc_en      in   1   update shift/carry flag from sc_in
//   sc_in      in   1   ALU sc_o
//   sc_out     out  1   registered shift/carry flag to ALU sc_i
//   flag_en    in   1   update branch flag
//   flag_sel   in   1   0: flag <= one_in, 1: flag <= pari_in
//   one_in     in   1   ALU one output
//   pari_in    in   1   ALU pari output
//   br_flag    out  1   registered branch flag to fetch/branch logic
// BEHAVIOUR
// - Reset (synchronous): all 2**A registers <= 0; wb_vld <= 0; sc_out <= 0; br_flag <= 0.
//   Reset asserted while a write is pending discards it; no commit occurs on that edge.
// - Two-stage writeback:
//   - Edge N with wr_en=1: wb_vld <= 1, wb_addr <= wr_addr, wb_data <= wr_data.
//   - Edge N with wr_en=0: wb_vld <= 0.
//   - Edge N+1: if wb_vld, core[wb_addr] <= wb_data.
//   - Write latency from wr_en to array: 2 edges; to visible read: 1 edge (bypass).
// - Read ports (combinational, independent):
//   - If wb_vld && wb_addr==rd_addrX: dat_out = wb_data (bypass); else core[rd_addrX].
//   - Same-cycle wr_data is NOT forwarded to reads; this breaks the ALU->regfile comb loop.
//   - A==B read addresses are legal; both ports return the same value.
// - Back-to-back writes, same address: on edge N+1 older value commits while newer is captured;
//   reads after N+1 see newer value via bypass; array holds newer after N+2. Newest write always wins.
// - Back-to-back writes, different addresses: both commit in order; no stall, no loss.
// - sc_out: on edge, if sc_en, sc_out <= sc_in; else holds. Update is independent of wr_en.
// - br_flag: on edge, if flag_en, br_flag <= (flag_sel ? pari_in : one_in); else holds.
// - All registers are D bits; no width conversion, no sign extension, no wrap logic.
// - No handshake or backpressure; every wr_en pulse is accepted.
// TESTING
// - Reset mid-pending write: wr_en=1 addr 3 data 8'hA5, reset on next edge -> reg3 reads 0, wb_vld 0.
// - Write then read: write r2=8'h3C at edge N; rd_addrA=2 -> 8'h3C after N (bypass) and after N+2 (array).
// - No same-cycle forward: r5=8'h11; during the wr_en cycle for r5=8'h22, rd_addrB=5 -> 8'h11.
// - Back-to-back same address: r1<=8'h01 then r1<=8'h02 on consecutive edges -> reads 01, then 02; final array r1=02.
// - Flags: sc_en=1 sc_in=1 -> sc_out=1; sc_en=0 sc_in=0 -> holds 1.
//   flag_en=1 flag_sel=1 pari_in=1 one_in=0 -> br_flag=1; flag_sel=0 -> br_flag=0.
// - Dual-port: r4=8'hF0, r7=8'h0F, rd_addrA=4 rd_addrB=7 -> datA_out=F0, datB_out=0F simultaneously.

Source files
------------

// File: rtl/reg_file_wb.sv
// Register file with a one-entry writeback stage sitting between the ALU result
// and the architectural array. Reads are combinational and bypass from the
// writeback stage. Same-cycle wr_data is never forwarded to the reads, so there
// is no combinational path from the ALU result back to the ALU operands.
// Also holds the shift/carry flag fed back to the ALU and the branch flag.
module reg_file_wb #(
   parameter int unsigned D = 8,
   parameter int unsigned A = 3
) (
   input  logic         clk,
   input  logic         reset,
   // read ports
   input  logic [A-1:0] rd_addrA,
   input  logic [A-1:0] rd_addrB,
   output logic [D-1:0] datA_out,
   output logic [D-1:0] datB_out,
   // writeback request
   input  logic         wr_en,
   input  logic [A-1:0] wr_addr,
   input  logic [D-1:0] wr_data,
   // shift/carry flag
   input  logic         sc_en,
   input  logic         sc_in,
   output logic         sc_out,
   // branch flag
   input  logic         flag_en,
   input  logic         flag_sel,
   input  logic         one_in,
   input  logic         pari_in,
   output logic         br_flag
);

   localparam int unsigned NumRegs = 2 ** A;

   // Architectural array
   logic [D-1:0] core_q [NumRegs];
   logic [D-1:0] core_d [NumRegs];

   // Writeback stage
   logic         wb_vld_q, wb_vld_d;
   logic [A-1:0] wb_addr_q, wb_addr_d;
   logic [D-1:0] wb_data_q, wb_data_d;

   // Flags
   logic         sc_q, sc_d;
   logic         br_q, br_d;

   // Bypass hit indications for each read port
   logic         hit_a, hit_b;

   // Commit the pending writeback into the array
   always_comb begin
      for (int i = 0; i < NumRegs; i++) begin
         core_d[i] = core_q[i];
      end
      if (wb_vld_q) begin
         core_d[wb_addr_q] = wb_data_q;
      end
   end

   // Capture a new writeback request; address/data hold when idle
   always_comb begin
      wb_vld_d  = wr_en;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      if (wr_en) begin
         wb_addr_d = wr_addr;
         wb_data_d = wr_data;
      end
   end

   // Flag next-state: load when enabled, otherwise hold
   always_comb begin
      sc_d = sc_q;
      br_d = br_q;
      if (sc_en) begin
         sc_d = sc_in;
      end
      if (flag_en) begin
         br_d = flag_sel ? pari_in : one_in;
      end
   end

   // State registers; reset drops any pending writeback without committing it
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NumRegs; i++) begin
            core_q[i] <= '0;
         end
         wb_vld_q  <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         sc_q      <= 1'b0;
         br_q      <= 1'b0;
      end else begin
         for (int i = 0; i < NumRegs; i++) begin
            core_q[i] <= core_d[i];
         end
         wb_vld_q  <= wb_vld_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         sc_q      <= sc_d;
         br_q      <= br_d;
      end
   end

   // Read ports: the writeback stage holds the newest value for its address
   always_comb begin
      hit_a    = wb_vld_q && (wb_addr_q == rd_addrA);
      hit_b    = wb_vld_q && (wb_addr_q == rd_addrB);
      datA_out = hit_a ? wb_data_q : core_q[rd_addrA];
      datB_out = hit_b ? wb_data_q : core_q[rd_addrB];
   end

   assign sc_out  = sc_q;
   assign br_flag = br_q;

endmodule
